// File: rtl/aes_sub_bytes_iter_pkg.sv
// Shared types, FSM encoding and FIPS-197 S-box tables for the iterative SubBytes engine.
package aes_sub_bytes_iter_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_NBYTES  = 16;

   typedef logic [0:AES_STATE_W-1] aes_state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [7:0] SBOX_FWD [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] SBOX_INV [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
      logic [7:0] r;
      if (inv) begin
         r = SBOX_INV[b];
      end else begin
         r = SBOX_FWD[b];
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_sub_bytes_iter_if.sv
// Upstream and downstream valid/ready channels of the SubBytes engine.
interface aes_sub_bytes_iter_if;
   import aes_sub_bytes_iter_pkg::*;

   logic       in_valid;
   logic       in_ready;
   aes_state_t in_state;
   logic       in_inv;
   logic       out_valid;
   logic       out_ready;
   aes_state_t out_state;

   modport slave (
      input  in_valid, in_state, in_inv, out_ready,
      output in_ready, out_valid, out_state
   );

   modport master (
      output in_valid, in_state, in_inv, out_ready,
      input  in_ready, out_valid, out_state
   );
endinterface

// File: rtl/aes_sub_bytes_iter_sbox.sv
// Single combinational forward/inverse AES S-box lane.
module aes_sub_bytes_iter_sbox
   import aes_sub_bytes_iter_pkg::*;
(
   input  logic [7:0] in_byte,
   input  logic       inv,
   output logic [7:0] out_byte
);
   assign out_byte = sbox_lookup(in_byte, inv);
endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative SubBytes/InvSubBytes: BPC shared S-box lanes walk the 16 state bytes over NCYC cycles.
module aes_sub_bytes_iter
   import aes_sub_bytes_iter_pkg::*;
#(
   parameter int BPC = 4
)(
   input  logic                 clk,
   input  logic                 rst_n,
   aes_sub_bytes_iter_if.slave  bus,
   output logic                 busy
);
   localparam int NCYC  = AES_NBYTES / BPC;
   localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   if ((BPC != 1) && (BPC != 2) && (BPC != 4) && (BPC != 8) && (BPC != 16)) begin : g_bpc_illegal
      $error("aes_sub_bytes_iter: BPC must be 1, 2, 4, 8 or 16");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             inv_q, inv_d;
   logic [7:0]       src_q [AES_NBYTES];
   logic [7:0]       src_d [AES_NBYTES];
   logic [7:0]       res_q [AES_NBYTES];
   logic [7:0]       res_d [AES_NBYTES];
   logic [7:0]       in_bytes_s [AES_NBYTES];
   logic             in_ready_s;
   logic [3:0]       lane_idx_s [BPC];
   logic [7:0]       lane_out_s [BPC];

   // Byte i of the flat state sits at bits [8i:8i+7].
   for (genvar i = 0; i < AES_NBYTES; i++) begin : g_bytes
      assign in_bytes_s[i]            = bus.in_state[8*i +: 8];
      assign bus.out_state[8*i +: 8]  = res_q[i];
   end

   for (genvar k = 0; k < BPC; k++) begin : g_lane
      assign lane_idx_s[k] = 4'((int'(cnt_q) * BPC) + k);
      aes_sub_bytes_iter_sbox u_sbox (
         .in_byte  (src_q[lane_idx_s[k]]),
         .inv      (inv_q),
         .out_byte (lane_out_s[k])
      );
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = (state_q == DONE);
   assign busy          = (state_q != IDLE);

   // Next-state, accept handshake and per-chunk result update.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      inv_d      = inv_q;
      src_d      = src_q;
      res_d      = res_q;
      in_ready_s = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_s = 1'b1;
            if (bus.in_valid) begin
               src_d   = in_bytes_s;
               inv_d   = bus.in_inv;
               cnt_d   = {CNT_W{1'b0}};
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            for (int k = 0; k < BPC; k++) begin
               res_d[lane_idx_s[k]] = lane_out_s[k];
            end
            if (cnt_q == CNT_LAST) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               state_d = BUSY;
            end
         end
         DONE: begin
            // Retiring the result and accepting the next block share one edge.
            if (bus.out_ready) begin
               in_ready_s = 1'b1;
               if (bus.in_valid) begin
                  src_d   = in_bytes_s;
                  inv_d   = bus.in_inv;
                  cnt_d   = {CNT_W{1'b0}};
                  state_d = BUSY;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and data registers; reset aborts any block in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         inv_q   <= 1'b0;
         src_q   <= '{default: 8'h00};
         res_q   <= '{default: 8'h00};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         inv_q   <= inv_d;
         src_q   <= src_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Bench for aes_sub_bytes_iter: engines with BPC 4, 1 and 16 driven from a vector table and
// directed sequences; results retire through per-engine scoreboards against a GF(2^8) S-box model.
`timescale 1ns/1ps
module tb_aes_sub_bytes_iter;
   import aes_sub_bytes_iter_pkg::*;

   typedef struct {
      int         g;
      logic       inv;
      aes_state_t din;
      aes_state_t dexp;
      int         lat;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tb_in_valid  [3];
   logic       tb_in_inv    [3];
   aes_state_t tb_in_state  [3];
   logic       tb_out_ready [3];
   logic       tb_in_ready  [3];
   logic       tb_out_valid [3];
   aes_state_t tb_out_state [3];
   logic       tb_busy      [3];

   aes_state_t exp_q [3][$];
   logic [7:0] m_fwd [256];
   logic [7:0] m_inv [256];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   // Engine 0: BPC=4, engine 1: BPC=1, engine 2: BPC=16.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      aes_sub_bytes_iter_if bus ();
      assign bus.in_valid     = tb_in_valid[g];
      assign bus.in_inv       = tb_in_inv[g];
      assign bus.in_state     = tb_in_state[g];
      assign bus.out_ready    = tb_out_ready[g];
      assign tb_in_ready[g]   = bus.in_ready;
      assign tb_out_valid[g]  = bus.out_valid;
      assign tb_out_state[g]  = bus.out_state;
      aes_sub_bytes_iter #(.BPC((g == 0) ? 4 : ((g == 1) ? 1 : 16))) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus),
         .busy  (tb_busy[g])
      );
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   // Forward S-box = multiplicative inverse followed by the affine map; inverse table by inversion.
   task automatic build_model();
      logic [7:0] iv;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         iv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
         end
         s = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
         m_fwd[x] = s;
         m_inv[s] = 8'(x);
      end
   endtask

   function automatic aes_state_t model_sub(input aes_state_t st, input logic inv);
      aes_state_t r;
      logic [7:0] b;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         b = st[8*i +: 8];
         r[8*i +: 8] = inv ? m_inv[b] : m_fwd[b];
      end
      return r;
   endfunction

   function automatic aes_state_t rand_state();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int g, input logic inv, input aes_state_t st, input aes_state_t exp,
                       input string name);
      int  n;
      logic done;
      n    = 0;
      done = 1'b0;
      tb_in_valid[g] = 1'b1;
      tb_in_inv[g]   = inv;
      tb_in_state[g] = st;
      exp_q[g].push_back(exp);
      while (!done) begin
         @(negedge clk);
         if (tb_in_ready[g]) begin
            done = 1'b1;
         end else if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: got in_ready=0 expected in_ready=1 within 50 cycles", name);
            done = 1'b1;
         end else begin
            n++;
         end
      end
      @(posedge clk);
      #1;
      tb_in_valid[g] = 1'b0;
   endtask

   // Counts edges from accept until out_valid; returns on the negedge where out_valid is seen.
   task automatic wait_result(input int g, input int lat, input logic wiggle, input string name);
      int   j;
      logic done;
      logic bad_busy;
      j        = 0;
      done     = 1'b0;
      bad_busy = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (tb_out_valid[g]) begin
            done = 1'b1;
         end else if (j > 40) begin
            done = 1'b1;
         end else begin
            bad_busy = bad_busy | tb_in_ready[g] | ~tb_busy[g];
            j++;
            if (wiggle) begin
               tb_in_inv[g]   = ~tb_in_inv[g];
               tb_in_state[g] = ~tb_in_state[g];
            end
         end
      end
      chk({name, "_latency"}, 128'(j), 128'(lat));
      chk({name, "_busy_not_ready"}, 128'(bad_busy), 128'(0));
   endtask

   // Scoreboard: retire one expected result on every output handshake.
   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (rst_n && tb_out_valid[g] && tb_out_ready[g]) begin
            if (exp_q[g].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_%0d: got %h expected no output", g, tb_out_state[g]);
            end else begin
               chk($sformatf("sb_out_%0d", g), tb_out_state[g], exp_q[g].pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs [8];
      aes_state_t sx, sy, ex, ey, s_tmp;
      logic       hold_ok;

      rst_n = 1'b0;
      for (int g = 0; g < 3; g++) begin
         tb_in_valid[g]  = 1'b0;
         tb_in_inv[g]    = 1'b0;
         tb_in_state[g]  = '0;
         tb_out_ready[g] = 1'b1;
      end
      build_model();

      vecs[0] = '{0, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, 4};
      vecs[1] = '{1, 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 16};
      vecs[2] = '{2, 1'b0, 128'h00000000000000000000000000000000, 128'h63636363636363636363636363636363, 1};
      vecs[3] = '{2, 1'b0, 128'h53535353535353535353535353535353, 128'hedededededededededededededededed, 1};
      vecs[4] = '{2, 1'b1, 128'h63636363636363636363636363636363, 128'h00000000000000000000000000000000, 1};
      s_tmp = rand_state();
      vecs[5] = '{0, 1'b1, s_tmp, model_sub(s_tmp, 1'b1), 4};
      s_tmp = rand_state();
      vecs[6] = '{1, 1'b0, s_tmp, model_sub(s_tmp, 1'b0), 16};
      s_tmp = rand_state();
      vecs[7] = '{2, 1'b1, s_tmp, model_sub(s_tmp, 1'b1), 1};

      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("rst_out_valid_%0d", g), 128'(tb_out_valid[g]), 128'(0));
         chk($sformatf("rst_in_ready_%0d", g), 128'(tb_in_ready[g]), 128'(1));
         chk($sformatf("rst_busy_%0d", g), 128'(tb_busy[g]), 128'(0));
         chk($sformatf("rst_out_state_%0d", g), tb_out_state[g], 128'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         send(vecs[i].g, vecs[i].inv, vecs[i].din, vecs[i].dexp, $sformatf("vec%0d", i));
         wait_result(vecs[i].g, vecs[i].lat, 1'b0, $sformatf("vec%0d", i));
         @(posedge clk);
         #1;
      end

      // Backpressure on engine 0, then retire and accept on the same edge.
      sx = rand_state();
      sy = rand_state();
      ex = model_sub(sx, 1'b0);
      ey = model_sub(sy, 1'b1);
      tb_out_ready[0] = 1'b0;
      send(0, 1'b0, sx, ex, "bp_x");
      wait_result(0, 4, 1'b0, "bp_x");
      hold_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (tb_out_state[0] !== ex || tb_out_valid[0] !== 1'b1 || tb_in_ready[0] !== 1'b0) hold_ok = 1'b0;
         @(negedge clk);
      end
      chk("bp_hold_stable", 128'(hold_ok), 128'(1));
      @(posedge clk);
      #1;
      tb_out_ready[0] = 1'b1;
      tb_in_valid[0]  = 1'b1;
      tb_in_inv[0]    = 1'b1;
      tb_in_state[0]  = sy;
      exp_q[0].push_back(ey);
      @(negedge clk);
      chk("bp_same_edge_ready", 128'(tb_in_ready[0]), 128'(1));
      @(posedge clk);
      #1;
      tb_in_valid[0] = 1'b0;
      chk("bp_no_idle_busy", 128'({tb_busy[0], tb_out_valid[0]}), 128'(2'b10));
      wait_result(0, 4, 1'b0, "bp_y");
      @(posedge clk);
      #1;

      // Asynchronous reset while engine 0 holds cnt=2.
      sx = rand_state();
      send(0, 1'b0, sx, model_sub(sx, 1'b0), "rst_mid");
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", 128'(tb_out_valid[0]), 128'(0));
      chk("rst_mid_out_state", tb_out_state[0], 128'h0);
      chk("rst_mid_in_ready", 128'(tb_in_ready[0]), 128'(1));
      chk("rst_mid_busy", 128'(tb_busy[0]), 128'(0));
      for (int g = 0; g < 3; g++) exp_q[g].delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      sx = rand_state();
      send(0, 1'b0, sx, model_sub(sx, 1'b0), "post_rst");
      wait_result(0, 4, 1'b0, "post_rst");
      @(posedge clk);
      #1;

      // Mode and data wiggled during a long BPC=1 block must not leak into the result.
      sx = rand_state();
      send(1, 1'b0, sx, model_sub(sx, 1'b0), "wiggle");
      wait_result(1, 16, 1'b1, "wiggle");
      @(posedge clk);
      #1;
      tb_in_inv[1] = 1'b0;

      repeat (4) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("sb_drained_%0d", g), 128'(exp_q[g].size()), 128'(0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
